// File: rtl/seg_pkg.sv
// Shared codes for the stopwatch 7-segment bus: active-low digit patterns,
// one-hot-low anode codes and digit slot indices.
package seg_pkg;

   localparam logic [6:0] SEG_D0    = 7'b1000000;
   localparam logic [6:0] SEG_D1    = 7'b1111001;
   localparam logic [6:0] SEG_D2    = 7'b0100100;
   localparam logic [6:0] SEG_D3    = 7'b0110000;
   localparam logic [6:0] SEG_D4    = 7'b0011001;
   localparam logic [6:0] SEG_D5    = 7'b0010010;
   localparam logic [6:0] SEG_D6    = 7'b0000010;
   localparam logic [6:0] SEG_D7    = 7'b1111000;
   localparam logic [6:0] SEG_D8    = 7'b0000000;
   localparam logic [6:0] SEG_D9    = 7'b0011000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_SLOT3 = 4'b1110;
   localparam logic [3:0] AN_SLOT2 = 4'b1101;
   localparam logic [3:0] AN_SLOT1 = 4'b1011;
   localparam logic [3:0] AN_SLOT0 = 4'b0111;

   localparam logic [1:0] SLOT_SEC_ONES = 2'd0;
   localparam logic [1:0] SLOT_SEC_TENS = 2'd1;
   localparam logic [1:0] SLOT_MIN_ONES = 2'd2;
   localparam logic [1:0] SLOT_MIN_TENS = 2'd3;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern into a BCD digit,
// a blank flag and an invalid flag.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] digit,
   output logic       blank,
   output logic       invalid
);

   always_comb begin
      digit   = 4'd0;
      blank   = 1'b0;
      invalid = 1'b0;
      case (pattern)
         SEG_D0:    digit = 4'd0;
         SEG_D1:    digit = 4'd1;
         SEG_D2:    digit = 4'd2;
         SEG_D3:    digit = 4'd3;
         SEG_D4:    digit = 4'd4;
         SEG_D5:    digit = 4'd5;
         SEG_D6:    digit = 4'd6;
         SEG_D7:    digit = 4'd7;
         SEG_D8:    digit = 4'd8;
         SEG_D9:    digit = 4'd9;
         SEG_BLANK: blank = 1'b1;
         default:   invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback monitor for the multiplexed 7-segment bus: synchronizes, filters and
// decodes each scanned digit, then publishes complete MM:SS frames.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] digits,
   output logic [3:0]  blank_mask,
   output logic [5:0]  minutes,
   output logic [5:0]  seconds,
   output logic        frame_valid,
   output logic        err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

   logic [6:0]       seg_p0, seg_s, seg_prev;
   logic [3:0]       an_p0, an_s, an_prev;
   logic [CNT_W-1:0] cnt;
   logic             armed;
   logic             same, capture;
   logic             slot_valid;
   logic [1:0]       slot;
   logic [3:0]       dec_digit;
   logic             dec_blank, dec_invalid;
   logic             take, bad, publish;
   logic [3:0]       seen, seen_nxt;
   logic [15:0]      stage_digits, stage_digits_nxt;
   logic [3:0]       stage_blank, stage_blank_nxt;

   function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
      logic [6:0] sum;
      sum = 7'(tens) * 7'd10 + 7'(ones);
      return sum[5:0];
   endfunction

   // Sync stage plus stability filter; sync flops idle high like an undriven bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_p0   <= '1;
         seg_s    <= '1;
         an_p0    <= '1;
         an_s     <= '1;
         seg_prev <= '1;
         an_prev  <= '1;
         cnt      <= '0;
         armed    <= 1'b1;
      end else begin
         seg_p0   <= seg;
         seg_s    <= seg_p0;
         an_p0    <= an;
         an_s     <= an_p0;
         seg_prev <= seg_s;
         an_prev  <= an_s;
         if (!same) begin
            cnt   <= '0;
            armed <= 1'b1;
         end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (capture) armed <= 1'b0;
         end
      end
   end

   assign same    = ({an_s, seg_s} == {an_prev, seg_prev});
   assign capture = same && armed && (cnt == CNT_ARM);

   always_comb begin
      slot_valid = 1'b1;
      slot       = SLOT_SEC_ONES;
      case (an_s)
         AN_SLOT3: slot = SLOT_MIN_TENS;
         AN_SLOT2: slot = SLOT_MIN_ONES;
         AN_SLOT1: slot = SLOT_SEC_TENS;
         AN_SLOT0: slot = SLOT_SEC_ONES;
         default:  slot_valid = 1'b0;
      endcase
   end

   seg_pattern_decode u_decode (
      .pattern (seg_s),
      .digit   (dec_digit),
      .blank   (dec_blank),
      .invalid (dec_invalid)
   );

   assign take = capture && slot_valid && !dec_invalid;
   assign bad  = capture && slot_valid && dec_invalid;

   // The capture in flight is merged here so a frame can publish on its own edge
   always_comb begin
      stage_digits_nxt = stage_digits;
      stage_blank_nxt  = stage_blank;
      seen_nxt         = seen;
      if (take) begin
         stage_digits_nxt[{slot, 2'b00} +: 4] = dec_digit;
         stage_blank_nxt[slot]                = dec_blank;
         seen_nxt[slot]                       = 1'b1;
      end
   end

   assign publish = take && (seen_nxt == 4'b1111);

   always_ff @(posedge clk) begin
      stage_digits <= stage_digits_nxt;
      stage_blank  <= stage_blank_nxt;
   end

   // Frame publish stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen        <= '0;
         digits      <= '0;
         blank_mask  <= '0;
         minutes     <= '0;
         seconds     <= '0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         frame_valid <= publish;
         if (bad) err <= 1'b1;
         if (publish) begin
            seen       <= '0;
            digits     <= stage_digits_nxt;
            blank_mask <= stage_blank_nxt;
            if (stage_blank_nxt == 4'b0000) begin
               minutes <= bcd_to_bin(stage_digits_nxt[15:12], stage_digits_nxt[11:8]);
               seconds <= bcd_to_bin(stage_digits_nxt[7:4], stage_digits_nxt[3:0]);
            end
         end else begin
            seen <= seen_nxt;
         end
      end
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Readback monitor for the stopwatch's multiplexed 7-segment bus. It samples the active-low segment and anode lines driven by the display multiplexer and decodes each scanned pattern back into a digit. It assembles the four digits into a frame and reports minutes/seconds, per-digit blanking and pattern errors. It sits beside the display driver on the board-level `seg`/`an` nets and feeds self-check logic and LED status.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is captured (≥2).
- `CNT_W`, 3: width of the stability counter; must hold `STABLE_CYCLES-1`.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seg`  in  7  segment lines, active low, bit 6 = g … bit 0 = a; asynchronous to `clk`.
- `an`  in  4  anode lines, active low; asynchronous to `clk`.
- `digits`  out  16  last complete frame as BCD: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- `blank_mask`  out  4  per-digit blank flag for the last frame, same ordering (bit 3 = min tens).
- `minutes`  out  6  binary minutes from the last fully unblanked frame.
- `seconds`  out  6  binary seconds from the last fully unblanked frame.
- `frame_valid`  out  1  one-cycle pulse when a new frame is published.
- `err`  out  1  sticky flag for an unrecognised segment pattern; cleared only by reset.

## Operation
- Synchronizer: `seg` and `an` each pass through a 2-flop synchronizer, giving `seg_s`/`an_s`.
- Anode decode: `an_s` maps to a digit slot only when exactly one bit is low.
  - 1110 → slot 3 (min tens); 1101 → slot 2; 1011 → slot 1; 0111 → slot 0 (sec ones).
  - Any other value (0000 during driver reset, 1111, multiple lows) is idle: no capture, no error.
- Stability filter: the `{an_s, seg_s}` pair is compared with the previous cycle's pair.
  - On any difference, the counter clears and capture re-arms.
  - Otherwise the counter increments and saturates at `STABLE_CYCLES-1`.
  - Capture fires once, in the cycle the counter reaches `STABLE_CYCLES-1` while armed; capture then disarms.
- Pattern decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - 1111111 = blank: stage BCD 0 and set the blank bit.
  - Any other pattern on a valid slot: set `err` and skip the capture (the seen bit is not set).
- Frame assembly: each capture writes the staged digit and blank bit for its slot and sets `seen[slot]`. A repeat capture to a slot overwrites the staged value.
- Publish: when `seen` becomes 1111 (including the capture in progress), in the same cycle:
  - copy the staged values to `digits`/`blank_mask`;
  - pulse `frame_valid`;
  - clear `seen`.
- Binary outputs: if the published `blank_mask` is 0000, `minutes` = tens·10 + ones, and likewise for `seconds`. Otherwise `minutes`/`seconds` hold their previous values. Digits above 5 in a tens slot pass through unchecked (max 99 fits in 7 bits; the result is truncated to 6).

## Timing
- Reset values: `digits`=0, `blank_mask`=0000, `minutes`=0, `seconds`=0, `frame_valid`=0, `err`=0. Synchronizer flops reset to 1 (idle), `seen`=0000, counter=0, capture armed.
- Latency from a pin change to capture: 2 sync cycles + `STABLE_CYCLES` cycles. `digits` and `frame_valid` update on the capture edge of the fourth distinct slot.
- A pattern held shorter than `STABLE_CYCLES` cycles is never captured.
- A held pattern is captured exactly once, however long it persists.
- Reset asserted mid-frame discards the staged digits and `seen`; the outputs return to their reset values immediately.
- `err` and a publish in the same cycle are independent; an erroring capture never completes a frame.

## Structure
- Shared package `seg_pkg`:
  - the ten digit codes and the blank code (shared with the display driver);
  - the four one-hot anode codes;
  - slot index constants.
- Sub-module `seg_pattern_decode`: combinational, 7-bit pattern → {digit[3:0], blank, invalid}. Reusable by other monitors.

## Test plan
- Scan 12:34 (min tens, min ones, sec tens, sec ones), each slot held 8 cycles:
  - one `frame_valid` pulse;
  - `digits`=0x1234, `blank_mask`=0000, `minutes`=12, `seconds`=34.
- Same scan with slots 1 and 2 blank (1111111):
  - `blank_mask`=0110, `digits`=0x1004;
  - `minutes`/`seconds` keep their prior values 12/34;
  - `err`=0.
- Slot 0 driven 0101010 for 8 cycles:
  - `err` rises and stays set;
  - no `frame_valid` until a valid slot-0 capture follows.
- Slot 3 pattern held for 3 cycles then changed, with `STABLE_CYCLES`=4:
  - no capture;
  - `seen` unchanged; no `frame_valid`.
- `an`=0000 with `seg`=1111111 for 50 cycles: no capture, `err`=0, no `frame_valid`.
- `rst_n` pulsed low after 3 of the 4 slots are captured:
  - outputs return to their reset values;
  - the next complete scan produces exactly one `frame_valid`.
